// File: rtl/acia_pkg.sv
// Shared ACIA definitions: state encoding, bit-timing derivation and frame constants.
package acia_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int DATA_BITS = 8;
`ifdef ACIA_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    function automatic int calc_sym_cnt(input int clk_freq, input int sym_rate);
        return clk_freq / sym_rate;
    endfunction

    // Keep at least one counter bit so a sym_cnt of 1 or 2 still elaborates.
    function automatic int calc_scw(input int sym_cnt);
        return (sym_cnt <= 2) ? 1 : $clog2(sym_cnt);
    endfunction

endpackage

// File: rtl/acia_fifo.sv
// Small synchronous FIFO with occupancy count; caller guarantees no write-when-full
// without a same-cycle read and no read-when-empty.
module acia_fifo #(
    parameter int depth = 4,
    parameter int width = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [width-1:0]           din,
    output logic [width-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(depth):0]     count
);
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wptr, rptr;

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + AW'(1);
            if (rd) rptr <= rptr + AW'(1);
            case ({wr, rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout  = mem[rptr];
    assign full  = (count == CW'(depth));
    assign empty = (count == '0);

endmodule

// File: rtl/acia_tx.sv
// ACIA serial transmitter: byte FIFO feeding an 8N1 serialiser timed by pclk.
// Define ACIA_TX_PARITY_EN to emit 8E1 frames with an even parity bit.
module acia_tx
    import acia_pkg::*;
#(
    parameter int clk_freq   = 3333333,
    parameter int sym_rate   = 115200,
    parameter int fifo_depth = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pclk,
    input  logic [7:0] tx_dat,
    input  logic       tx_start,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_full,
    output logic       tx_ovr
);
    localparam int SYM = calc_sym_cnt(clk_freq, sym_rate);
    localparam int SCW = calc_scw(SYM);
    localparam int CW  = $clog2(fifo_depth) + 1;
    localparam logic [SCW-1:0] RLOAD = SCW'(SYM - 1);

    logic [2:0]     state;
    logic [SCW-1:0] rcnt;
    logic [2:0]     bcnt;
    logic [7:0]     sr;
`ifdef ACIA_TX_PARITY_EN
    logic           par;
`endif

    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          pop, wr_ok;

    assign pop   = pclk && (state == ST_IDLE) && !fifo_empty;
    // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
    assign wr_ok = tx_start && (!fifo_full || pop);

    acia_fifo #(.depth(fifo_depth), .width(8)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr      (wr_ok),
        .rd      (pop),
        .din     (tx_dat),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign tx_full = fifo_full;
    assign tx_busy = (state != ST_IDLE) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (!reset_n)                tx_ovr <= 1'b0;
        else if (tx_start && !wr_ok) tx_ovr <= 1'b1;
        else if (wr_ok)              tx_ovr <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            rcnt      <= '0;
            bcnt      <= '0;
            sr        <= '0;
            tx_serial <= 1'b1;
`ifdef ACIA_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else if (pclk) begin
            case (state)
                ST_IDLE: begin
                    tx_serial <= 1'b1;
                    if (!fifo_empty) begin
                        sr        <= fifo_dout;
                        rcnt      <= RLOAD;
                        state     <= ST_START;
                        tx_serial <= 1'b0;
`ifdef ACIA_TX_PARITY_EN
                        par       <= ^fifo_dout;
`endif
                    end
                end
                ST_START: begin
                    if (rcnt == '0) begin
                        rcnt      <= RLOAD;
                        bcnt      <= 3'd7;
                        state     <= ST_DATA;
                        tx_serial <= sr[0];
                    end else begin
                        rcnt <= rcnt - SCW'(1);
                    end
                end
                ST_DATA: begin
                    if (rcnt == '0) begin
                        rcnt <= RLOAD;
                        if (bcnt == '0) begin
`ifdef ACIA_TX_PARITY_EN
                            state     <= ST_PARITY;
                            tx_serial <= par;
`else
                            state     <= ST_STOP;
                            tx_serial <= 1'b1;
`endif
                        end else begin
                            sr        <= sr >> 1;
                            bcnt      <= bcnt - 3'd1;
                            tx_serial <= sr[1];
                        end
                    end else begin
                        rcnt <= rcnt - SCW'(1);
                    end
                end
`ifdef ACIA_TX_PARITY_EN
                ST_PARITY: begin
                    if (rcnt == '0) begin
                        rcnt      <= RLOAD;
                        state     <= ST_STOP;
                        tx_serial <= 1'b1;
                    end else begin
                        rcnt <= rcnt - SCW'(1);
                    end
                end
`endif
                ST_STOP: begin
                    tx_serial <= 1'b1;
                    if (rcnt == '0) state <= ST_IDLE;
                    else            rcnt  <= rcnt - SCW'(1);
                end
                default: begin
                    state     <= ST_IDLE;
                    tx_serial <= 1'b1;
                end
            endcase
        end
    end

endmodule
